// File: rtl/shift_reg_serdes.sv
// shift_reg_serdes
// Universal shift register with a built-in burst serializer/deserializer.
// In IDLE it performs one manual op per cycle. A start pulse loads din and
// shifts it out serially over WIDTH cycles while capturing sin.
//
// Optional feature macro: SHIFT_PARITY_EN
//   When defined, adds a registered even-parity output. It is updated only
//   on the edge that ends a burst.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   op      manual op in IDLE: 00 hold, 01 load din, 10 shift right, 11 shift left
//   start   begin a burst (sampled only in IDLE, has priority over op)
//   dir     burst direction, sampled with start: 0 right/LSB first, 1 left/MSB first
//   sin     serial data in
//   din     parallel data in
//   q       register contents
//   sout    serial data out (combinational)
//   busy    burst in progress
//   done    one-cycle pulse after the final burst shift
//   parity  (SHIFT_PARITY_EN only) XOR of q latched at burst end
module shift_reg_serdes #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             dir,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
`ifdef SHIFT_PARITY_EN
  output logic             done,
  output logic             parity
`else
  output logic             done
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             dir_reg, dir_next;
  logic             done_reg, done_next;
`ifdef SHIFT_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  logic [WIDTH-1:0] shr, shl, burst_shift;

  assign shr         = {sin, q_reg[WIDTH-1:1]};
  assign shl         = {q_reg[WIDTH-2:0], sin};
  assign burst_shift = dir_reg ? shl : shr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      q_reg      <= RESET_VAL;
      cnt_reg    <= '0;
      dir_reg    <= 1'b0;
      done_reg   <= 1'b0;
`ifdef SHIFT_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      q_reg      <= q_next;
      cnt_reg    <= cnt_next;
      dir_reg    <= dir_next;
      done_reg   <= done_next;
`ifdef SHIFT_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    q_next      = q_reg;
    cnt_next    = cnt_reg;
    dir_next    = dir_reg;
    done_next   = 1'b0;
`ifdef SHIFT_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          q_next     = din;
          dir_next   = dir;
          cnt_next   = '0;
          state_next = BURST;
        end else begin
          case (op)
            2'b01:   q_next = din;
            2'b10:   q_next = shr;
            2'b11:   q_next = shl;
            default: q_next = q_reg;
          endcase
        end
      end
      BURST: begin
        q_next   = burst_shift;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          // Clear rather than increment so the counter never passes WIDTH-1
          // when WIDTH is not a power of two.
          cnt_next   = '0;
          done_next  = 1'b1;
          state_next = IDLE;
`ifdef SHIFT_PARITY_EN
          parity_next = ^burst_shift;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign q    = q_reg;
  assign busy = (state_reg == BURST);
  assign done = done_reg;
`ifdef SHIFT_PARITY_EN
  assign parity = parity_reg;
`endif

  // Outside a burst the tap follows the manual op so a right shift exposes
  // the LSB that is about to leave; every other op exposes the MSB.
  always_comb begin
    if (busy) sout = dir_reg ? q_reg[WIDTH-1] : q_reg[0];
    else      sout = (op == 2'b10) ? q_reg[0] : q_reg[WIDTH-1];
  end

endmodule

// File: tb/tb_shift_reg_serdes.sv
module tb_shift_reg_serdes;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   op;
  logic         start;
  logic         dir;
  logic         sin;
  logic [W-1:0] din;
  logic [W-1:0] q;
  logic         sout;
  logic         busy;
  logic         done;
`ifdef SHIFT_PARITY_EN
  logic         parity;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] q;     // final register value after the burst
    logic [W-1:0] bits;  // bits[k] = k-th bit expected on sout
  } exp_t;
  exp_t exp_q[$];

  logic [W-1:0] mq;      // reference model of q

  shift_reg_serdes #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
    .clk(clk), .reset(reset), .op(op), .start(start), .dir(dir), .sin(sin),
    .din(din), .q(q), .sout(sout), .busy(busy),
`ifdef SHIFT_PARITY_EN
    .done(done), .parity(parity)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int           bcnt = 0;
  int           nbits = 0;
  logic [W-1:0] got;
  logic         prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t r;
    if (reset) begin
      bcnt = 0; nbits = 0; prev_done = 1'b0;
    end else begin
      if (busy) begin
        if (nbits < W) got[nbits] = sout;
        nbits++;
        bcnt++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("stray_done", 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          chk("burst_q", q, r.q);
          chk("burst_sout_bits", got, r.bits);
          chk("busy_cycles", bcnt, W);
`ifdef SHIFT_PARITY_EN
          chk("parity", parity, ^r.q);
`endif
          $display("burst done: q=%b sout_bits=%b busy_cycles=%0d", q, got, bcnt);
        end
        bcnt = 0; nbits = 0;
      end
      if (done && prev_done) chk("done_one_cycle", 32'd1, 32'd0);
      prev_done = done;
    end
  end

  // ---------------- driver ----------------
  task automatic manual(input logic [1:0] o, input logic [W-1:0] d, input logic s);
    logic [W-1:0] nq;
    start = 1'b0; op = o; din = d; sin = s;
    #1;
    chk("idle_sout", sout, (o == 2'b10) ? mq[0] : mq[W-1]);
    case (o)
      2'b01:   nq = d;
      2'b10:   begin nq = mq >> 1; nq[W-1] = s; end
      2'b11:   begin nq = mq << 1; nq[0] = s; end
      default: nq = mq;
    endcase
    @(posedge clk); #1;
    mq = nq;
    chk("manual_q", q, mq);
    $display("manual op=%b din=%b sin=%b -> q=%b", o, d, s, q);
  endtask

  // sbits[k] is the sin value sampled at burst edge E(k+1).
  task automatic burst(input logic [W-1:0] d, input logic dr,
                       input logic [W-1:0] sbits, input bit junk);
    exp_t r;
    for (int k = 0; k < W; k++) begin
      r.bits[k] = dr ? d[W-1-k] : d[k];
      // The first captured bit ends at q[0] (right) or q[W-1] (left).
      if (dr) r.q[W-1-k] = sbits[k];
      else    r.q[k]     = sbits[k];
    end
    exp_q.push_back(r);
    start = 1'b1; dir = dr; din = d; op = 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    chk("busy_after_start", busy, 1'b1);
    for (int k = 0; k < W; k++) begin
      start = junk ? 1'b1 : 1'b0;
      op    = junk ? 2'b01 : 2'($urandom_range(0, 3));
      din   = junk ? '1 : W'($urandom);
      dir   = 1'($urandom);
      sin   = sbits[k];
      @(posedge clk); #1;
    end
    start = 1'b0; op = 2'b00; dir = 1'b0;
    mq = r.q;
    $display("burst issued: dir=%b din=%b sin_bits=%b junk=%0d", dr, d, sbits, junk);
  endtask

  task automatic reset_mid_burst();
    start = 1'b1; dir = 1'($urandom); din = W'($urandom);
    @(posedge clk); #1;           // E0
    start = 1'b0; sin = 1'($urandom);
    @(posedge clk); #1;           // E1
    sin = 1'($urandom);
    @(posedge clk); #1;           // E2
    #2 reset = 1'b1;
    #1;
    chk("midburst_reset_q", q, 4'b0000);
    chk("midburst_reset_busy", busy, 1'b0);
    chk("midburst_reset_done", done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    mq = '0;
    $display("reset mid-burst: q=%b busy=%b", q, busy);
  endtask

  initial begin
    reset = 1'b1; op = 2'b00; start = 1'b0; dir = 1'b0; sin = 1'b0; din = '0;
    mq = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_q", q, 4'b0000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);

    // Manual ops
    manual(2'b01, 4'b1010, 1'b0);
    manual(2'b10, 4'b0000, 1'b1);
    manual(2'b11, 4'b0000, 1'b0);
    repeat (3) manual(2'b00, 4'b0101, 1'b1);

    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    chk("async_reset_q", q, 4'b0000);
    chk("async_reset_busy", busy, 1'b0);
    chk("async_reset_done", done, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    mq = '0;

    // Directed bursts
    burst(4'b0110, 1'b0, 4'b1101, 1'b0);   // sin 1,0,1,1 -> q=1101
    manual(2'b00, 4'b0000, 1'b0);
    burst(4'b0110, 1'b1, 4'b0011, 1'b0);   // sin 1,1,0,0 -> q=1100
    manual(2'b00, 4'b0000, 1'b0);
    // Ignored inputs during a burst, then back-to-back start in the done cycle
    burst(4'b1001, 1'b0, 4'b0101, 1'b1);
    burst(4'b0011, 1'b1, 4'b1110, 1'b0);
    manual(2'b00, 4'b0000, 1'b0);

    reset_mid_burst();
    repeat (3) manual(2'b00, 4'b0000, 1'b0);

    // Randomized mix
    repeat (30) begin
      case ($urandom_range(0, 3))
        0, 1: manual(2'($urandom_range(0, 3)), W'($urandom), 1'($urandom));
        2:    burst(W'($urandom), 1'($urandom), W'($urandom), 1'($urandom));
        default: begin
          burst(W'($urandom), 1'($urandom), W'($urandom), 1'($urandom));
          burst(W'($urandom), 1'($urandom), W'($urandom), 1'($urandom));
        end
      endcase
    end
    repeat (2) manual(2'b00, 4'b0000, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_reg_serdes.md
Name: shift_reg_serdes

Overview:
- Parametrised universal shift register with a built-in burst serializer/deserializer.
- In IDLE it executes per-cycle manual ops: hold, parallel load, shift right, shift left.
- A start pulse loads a parallel word, then automatically shifts it out serially over WIDTH cycles. The serial input is captured at the same time, and done is flagged on completion.
- Used as the serial link front-end between parallel datapaths and bit-serial peripherals.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VAL, 0, value of q after reset; WIDTH bits.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high; forces reset state immediately.
- op  input  2  manual op in IDLE: 00 hold, 01 load din, 10 shift right, 11 shift left.
- start  input  1  begin burst; sampled only in IDLE.
- dir  input  1  burst direction: 0 = right (LSB first), 1 = left (MSB first); sampled with start.
- sin  input  1  serial data in.
- din  input  WIDTH  parallel data in.
- q  output  WIDTH  register contents.
- sout  output  1  serial data out; combinational from q and direction.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after the final burst shift.

Behaviour:
- Reset (async, active-high):
  - q = RESET_VAL, busy = 0, done = 0, state = IDLE.
  - Bit counter = 0, latched direction = 0.
  - Reset takes effect immediately, mid-burst included. No done pulse follows a reset.
- Shift definitions:
  - Right: q <= {sin, q[WIDTH-1:1]}.
  - Left: q <= {q[WIDTH-2:0], sin}.
- sout:
  - When busy, sout = q[0] if latched dir = 0, else q[WIDTH-1].
  - When not busy, sout = q[0] if op = 10, else q[WIDTH-1].
- done: defaults to 0 every cycle unless set by the final burst shift.
- State IDLE:
  - If start = 1: q <= din, latch dir, cnt <= 0, busy <= 1, go to BURST. start has priority over op.
  - Otherwise execute op: 00 hold, 01 q <= din, 10 shift right, 11 shift left.
- State BURST:
  - Every edge: shift in the latched direction, cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1: perform that final shift, busy <= 0, done <= 1, go to IDLE.
  - start, op, dir and din are ignored. A start asserted while busy is dropped, not queued.
- Timing, with start sampled at edge E0:
  - Shifts occur at E1..E_WIDTH.
  - busy is high after E0 through E_WIDTH, i.e. exactly WIDTH cycles.
  - done is high for the cycle after E_WIDTH.
- Burst data ordering:
  - Out: din bit 0 first (right) or bit WIDTH-1 first (left).
  - In: after a right burst, the first sin bit sits in q[0]; after a left burst, it sits in q[WIDTH-1].
- Back-to-back bursts: start may be asserted in the cycle where done = 1. That cycle is IDLE, so the new burst begins with no gap.
- Counter: $clog2(WIDTH) bits; never exceeds WIDTH-1.

Optional Feature:
- Macro: SHIFT_PARITY_EN
- Defined:
  - Adds output port parity (1 bit): even parity (XOR) of q, registered.
  - Updated only on the edge that ends a burst, so it is valid together with done and holds its value until the next burst end.
  - Reset value 0.
- Undefined: no parity port or logic; all other behaviour is identical.

Test Plan (WIDTH=4, RESET_VAL=0):
- Reset check: assert reset asynchronously between edges -> q=0000, busy=0, done=0, without waiting for a clock edge.
- Manual ops:
  - op=01, din=1010 -> q=1010.
  - Then op=10, sin=1 -> q=1101.
  - Then op=11, sin=0 -> q=1010.
  - Then op=00 for 3 cycles -> q stays 1010.
- Right burst: start=1, dir=0, din=0110, sin = 1,0,1,1 at E1..E4 -> sout before E1..E4 = 0,1,1,0; busy high 4 cycles; q=1101 after E4; done=1 for one cycle.
- Left burst: start=1, dir=1, din=0110, sin = 1,1,0,0 at E1..E4 -> sout = 0,1,1,0 (MSB first); final q=1100; done pulse.
- Ignore rules: during a burst, drive start=1, op=01, din=1111 -> no reload, busy still drops after exactly 4 cycles. Then start asserted in the done cycle -> new burst starts with busy continuous.
- Reset mid-burst: assert reset after E2 -> q=0000 and busy=0 immediately; no done pulse after release. With SHIFT_PARITY_EN, parity=1 after a burst ending at q=1101.
